alu_sequencer: RTL
==================

Name: alu_sequencer

Overview:
- Multicycle control FSM for the ALU datapath: operand-A mux, operand-B mux, ALU, ALUOut register and SP register.
- Accepts one decoded command with a start/done handshake.
- Drives mux selects, ALU_op and the ALUOutWrite/SpWrite strobes cycle by cycle.
- Returns a registered branch decision for compare commands.
- Sits between the top-level control unit and the ALU datapath.

Parameters:
ALU_ADD, 3'b000, ALU_op encoding for add
ALU_SUB, 3'b001, ALU_op encoding for subtract
ALU_AND, 3'b010, ALU_op encoding for and
ALU_OR, 3'b011, ALU_op encoding for or
ALU_BEQ, 3'b100, ALU_op encoding for equality compare (drives BranchResult)
ALU_BLE, 3'b101, ALU_op encoding for less-or-equal compare (drives BLEResult)

Ports:
CLK  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
start  in  1  command request, sampled only in IDLE
cmd  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 BEQ, 5 BLE, 6 PUSH, 7 POP
cmd_imm  in  1  operand-B source: 0 = B (memory data), 1 = C (immediate); ignored for PUSH/POP
BranchResult  in  1  from ALU
BLEResult  in  1  from ALU
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at command completion
taken  out  1  registered compare outcome, valid when done is high
ASA_op  out  2  A-mux select: 00 A (accumulator), 01 C, 10 D (SP)
ASB_op  out  2  B-mux select: 00 B, 01 C (immediate / constant 2), 10 D
ALU_op  out  3  ALU operation
ALUOutWrite  out  1  ALUOut load strobe
SpWrite  out  1  SP register load strobe

Behaviour:
- States: IDLE, EXEC, SPUPD, DONE. Encoding is free.
- All outputs are registered Moore decodes of state and latched command, cmd_q and imm_q.
- Reset (reset==0 at a clock edge):
  - state goes to IDLE; cmd_q and imm_q go to 0.
  - busy, done, taken, ALUOutWrite and SpWrite go to 0; ASA_op and ASB_op go to 00; ALU_op goes to ALU_ADD.
  - Reset overrides any state mid-command. No strobe may fire in the cycle after reset.
- IDLE:
  - Outputs hold reset values.
  - If start==1, latch cmd and cmd_imm and go to EXEC.
- EXEC, arithmetic commands (0-3):
  - ASA_op=00; ASB_op=imm_q?01:00.
  - ALU_op = ADD/SUB/AND/OR per cmd_q; ALUOutWrite=1.
  - Next state: DONE.
- EXEC, compare commands (4-5):
  - ASA_op=00; ASB_op=imm_q?01:00.
  - ALU_op = ALU_BEQ or ALU_BLE; ALUOutWrite=0.
  - At the EXEC clock edge, taken <= BranchResult for cmd 4, BLEResult for cmd 5.
  - Next state: DONE.
- EXEC, PUSH/POP (6-7):
  - ASA_op=10 (SP); ASB_op=01 (constant 2).
  - ALU_op = ALU_SUB for PUSH, ALU_ADD for POP; ALUOutWrite=1.
  - Next state: SPUPD.
- SPUPD:
  - SpWrite=1, so SP loads ALUOutOut (SP∓2). All other strobes are 0.
  - Next state: DONE.
- DONE:
  - done=1 and busy=1; taken holds its value.
  - taken is cleared to 0 on the next start of a non-compare command.
  - Next state: IDLE.
- Latency from start to done: arithmetic and compare 2 cycles; PUSH/POP 3 cycles.
- start while busy is ignored (unless the optional feature is enabled).
- At most one strobe is high in any cycle. ALUOutWrite and SpWrite are never high together.

Optional Feature:
ALU_SEQ_PENDING_EN
- Defined:
  - Adds a one-entry pending buffer (valid, cmd, imm). start while busy captures it; a second start while the buffer is full is dropped.
  - In DONE, a valid pending entry transfers to cmd_q/imm_q and the FSM goes directly to EXEC, skipping IDLE. The buffer is then cleared.
  - An extra output pend_full (1 bit) reports buffer occupancy; reset clears it.
- Undefined: no buffer, no pend_full port, start while busy is ignored.

Test Plan:
1. Reset low for 2 cycles, release; hold start=0 -> all outputs at reset values, busy=0 for 5 cycles.
2. start with cmd=0, cmd_imm=1 -> next cycle ASA_op=00, ASB_op=01, ALU_op=000, ALUOutWrite=1; following cycle done=1; then busy=0.
3. cmd=6 (PUSH) with SP=16'h0100 -> EXEC ALU_op=001, ASA_op=10, ASB_op=01, ALUOutWrite=1; SPUPD SpWrite=1; SP reads 16'h00FE; done 3 cycles after start.
4. cmd=5 (BLE), ALU BLEResult=1 -> taken=1 with done. Then cmd=4 with BranchResult=0 -> taken=0.
5. start cmd=7 while busy in SPUPD -> ignored, no extra strobes. With ALU_SEQ_PENDING_EN defined -> pend_full=1; DONE goes directly to EXEC of cmd 7; done pulses back-to-back 3 cycles apart.
6. reset driven low during SPUPD -> SpWrite=0 on the next cycle, state IDLE, done never pulses.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: multicycle control FSM for the ALU datapath.
// It accepts one decoded command through a start/done handshake. It then steps the
// operand muxes, the ALU operation and the ALUOut/SP load strobes cycle by cycle.
//
// Ports:
//   CLK           clock, rising edge
//   reset         synchronous active-low reset
//   start         command request (accepted in IDLE)
//   cmd[2:0]      0 ADD, 1 SUB, 2 AND, 3 OR, 4 BEQ, 5 BLE, 6 PUSH, 7 POP
//   cmd_imm       operand-B source: 0 = B, 1 = C (ignored for PUSH/POP)
//   BranchResult  equality result from ALU
//   BLEResult     less-or-equal result from ALU
//   busy          high whenever the FSM is not in IDLE
//   done          one-cycle completion pulse
//   taken         registered compare outcome, valid with done
//   ASA_op[1:0]   A-mux select: 00 A, 01 C, 10 D (SP)
//   ASB_op[1:0]   B-mux select: 00 B, 01 C (immediate / constant 2), 10 D
//   ALU_op[2:0]   ALU operation
//   ALUOutWrite   ALUOut load strobe
//   SpWrite       SP register load strobe
//   pend_full     pending buffer occupied (only with ALU_SEQ_PENDING_EN)
//
// Optional feature macro: ALU_SEQ_PENDING_EN. It adds a one-entry pending command buffer,
// which is filled by a start that arrives while the FSM is busy.
//
// state | meaning
// IDLE  | waiting for start, outputs at reset values
// EXEC  | ALU operation in flight, ALUOut loads for arithmetic/stack
// SPUPD | SP loads ALUOut (PUSH/POP only)
// DONE  | done pulse, taken valid

module alu_sequencer #(
  parameter logic [2:0] ALU_ADD = 3'b000,
  parameter logic [2:0] ALU_SUB = 3'b001,
  parameter logic [2:0] ALU_AND = 3'b010,
  parameter logic [2:0] ALU_OR  = 3'b011,
  parameter logic [2:0] ALU_BEQ = 3'b100,
  parameter logic [2:0] ALU_BLE = 3'b101
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] cmd,
  input  logic       cmd_imm,
  input  logic       BranchResult,
  input  logic       BLEResult,
  output logic       busy,
  output logic       done,
  output logic       taken,
  output logic [1:0] ASA_op,
  output logic [1:0] ASB_op,
  output logic [2:0] ALU_op,
  output logic       ALUOutWrite,
  output logic       SpWrite
`ifdef ALU_SEQ_PENDING_EN
  ,
  output logic       pend_full
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, SPUPD, DONE} state_t;

  state_t     state;
  logic [2:0] cmd_q;
  logic       imm_q;

`ifdef ALU_SEQ_PENDING_EN
  logic [2:0] pend_cmd;
  logic       pend_imm;
`endif

  logic       launch;
  logic [2:0] l_cmd;
  logic       l_imm;

  function automatic logic is_cmp(input logic [2:0] c);
    return (c == 3'd4) || (c == 3'd5);
  endfunction

  function automatic logic is_stack(input logic [2:0] c);
    return c[2] & c[1];
  endfunction

  // EXEC-cycle selects {ASA_op, ASB_op, ALU_op}. These are decoded when a command is
  // accepted, so they are already registered when EXEC begins.
  function automatic logic [6:0] exec_sel(input logic [2:0] c, input logic imm);
    logic [2:0] op;
    if (is_stack(c))
      return {2'b10, 2'b01, (c[0] ? ALU_ADD : ALU_SUB)};
    case (c)
      3'd0:    op = ALU_ADD;
      3'd1:    op = ALU_SUB;
      3'd2:    op = ALU_AND;
      3'd3:    op = ALU_OR;
      3'd4:    op = ALU_BEQ;
      default: op = ALU_BLE;
    endcase
    return {2'b00, (imm ? 2'b01 : 2'b00), op};
  endfunction

  // A command enters EXEC from IDLE on start. With the pending buffer enabled, a command
  // can also enter EXEC directly from DONE. In that case a buffered entry takes priority
  // over a fresh start.
  always_comb begin
    launch = 1'b0;
    l_cmd  = cmd;
    l_imm  = cmd_imm;
    if (state == IDLE) begin
      launch = start;
    end
`ifdef ALU_SEQ_PENDING_EN
    else if (state == DONE) begin
      if (pend_full) begin
        launch = 1'b1;
        l_cmd  = pend_cmd;
        l_imm  = pend_imm;
      end else begin
        launch = start;
      end
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state       <= IDLE;
      cmd_q       <= 3'd0;
      imm_q       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      taken       <= 1'b0;
      ASA_op      <= 2'b00;
      ASB_op      <= 2'b00;
      ALU_op      <= ALU_ADD;
      ALUOutWrite <= 1'b0;
      SpWrite     <= 1'b0;
`ifdef ALU_SEQ_PENDING_EN
      pend_full   <= 1'b0;
      pend_cmd    <= 3'd0;
      pend_imm    <= 1'b0;
`endif
    end else begin
      done        <= 1'b0;
      ALUOutWrite <= 1'b0;
      SpWrite     <= 1'b0;
      ASA_op      <= 2'b00;
      ASB_op      <= 2'b00;
      ALU_op      <= ALU_ADD;
      if (launch) begin
        state                    <= EXEC;
        cmd_q                    <= l_cmd;
        imm_q                    <= l_imm;
        busy                     <= 1'b1;
        {ASA_op, ASB_op, ALU_op} <= exec_sel(l_cmd, l_imm);
        ALUOutWrite              <= !is_cmp(l_cmd);
        if (!is_cmp(l_cmd))
          taken <= 1'b0;
      end else begin
        case (state)
          IDLE: busy <= 1'b0;
          EXEC: begin
            // The ALU evaluates the compare during EXEC, so its result is sampled here.
            if (is_cmp(cmd_q))
              taken <= (cmd_q == 3'd4) ? BranchResult : BLEResult;
            busy <= 1'b1;
            if (is_stack(cmd_q)) begin
              state   <= SPUPD;
              SpWrite <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
          SPUPD: begin
            state <= DONE;
            busy  <= 1'b1;
            done  <= 1'b1;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
`ifdef ALU_SEQ_PENDING_EN
      if (state == DONE && pend_full) begin
        pend_full <= 1'b0;
      end else if (start && !pend_full && (state == EXEC || state == SPUPD)) begin
        pend_full <= 1'b1;
        pend_cmd  <= cmd;
        pend_imm  <= cmd_imm;
      end
`endif
    end
  end

endmodule
